// File: rtl/nes_pkg.sv
// Shared NES bus definitions: register addresses and DMA state encoding.
package nes_pkg;
  typedef enum logic [2:0] {
    IDLE,
    HALT,
    ALIGN,
    READ,
    WRITE
  } dma_state_t;

  localparam logic [15:0] ADDR_OAMDMA  = 16'h4014;
  localparam logic [15:0] ADDR_OAMDATA = 16'h2004;
  localparam int          PAGE_LEN     = 256;
  localparam logic [7:0]  LAST_IDX     = 8'(PAGE_LEN - 1);
endpackage

// File: rtl/oam_dma.sv
// Sprite OAM DMA: halts the cpu and copies one 256-byte page to $2004.
module oam_dma
  import nes_pkg::*;
#(
  parameter logic [15:0] DMA_REG_ADDR  = ADDR_OAMDMA,
  parameter logic [15:0] OAM_DATA_ADDR = ADDR_OAMDATA
) (
  input  logic        cpuClk,
  input  logic        reset,
  input  logic [15:0] cpuAddr,
  input  logic [7:0]  cpuDataWr,
  input  logic        cpuWrEn,
  input  logic [7:0]  busDataRd,
  output logic [15:0] busAddr,
  output logic [7:0]  busDataWr,
  output logic        busWrEn,
  output logic        cpuRdy,
  output logic        dmaActive,
  output logic        dmaDone
);

  dma_state_t state;
  logic [7:0] page;
  logic [7:0] idx;
  logic [7:0] latch;
  logic       getCycle;

  logic trig;
  assign trig = cpuWrEn && (cpuAddr == DMA_REG_ADDR);

  always_ff @(posedge cpuClk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      page      <= '0;
      idx       <= '0;
      latch     <= '0;
      getCycle  <= 1'b0;
      cpuRdy    <= 1'b1;
      dmaActive <= 1'b0;
      dmaDone   <= 1'b0;
    end else begin
      getCycle <= ~getCycle;
      dmaDone  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (trig) begin
            page      <= cpuDataWr;
            idx       <= '0;
            state     <= HALT;
            cpuRdy    <= 1'b0;
            dmaActive <= 1'b1;
          end
        end
        // reads must land on getCycle==1, so odd halts need one more cycle
        HALT:  state <= getCycle ? ALIGN : READ;
        ALIGN: state <= READ;
        READ: begin
          latch <= busDataRd;
          state <= WRITE;
        end
        WRITE: begin
          if (idx == LAST_IDX) begin
            state     <= IDLE;
            dmaDone   <= 1'b1;
            cpuRdy    <= 1'b1;
            dmaActive <= 1'b0;
          end else begin
            idx   <= idx + 8'd1;
            state <= READ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    busAddr   = cpuAddr;
    busDataWr = cpuDataWr;
    busWrEn   = cpuWrEn;
    unique case (state)
      IDLE: ;
      HALT, ALIGN: begin
        busDataWr = latch;
        busWrEn   = 1'b0;
      end
      READ: begin
        busAddr   = {page, idx};
        busDataWr = latch;
        busWrEn   = 1'b0;
      end
      WRITE: begin
        busAddr   = OAM_DATA_ADDR;
        busDataWr = latch;
        busWrEn   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_oam_dma.sv
// Bench for oam_dma: memory model, bus monitor, directed and random transfers.
module tb_oam_dma;
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cpuAddr;
  logic [7:0]  cpuDataWr;
  logic        cpuWrEn;
  logic [7:0]  busDataRd;
  logic [15:0] busAddr;
  logic [7:0]  busDataWr;
  logic        busWrEn;
  logic        cpuRdy;
  logic        dmaActive;
  logic        dmaDone;

  oam_dma dut (
    .cpuClk(clk), .reset(reset),
    .cpuAddr(cpuAddr), .cpuDataWr(cpuDataWr), .cpuWrEn(cpuWrEn),
    .busDataRd(busDataRd), .busAddr(busAddr), .busDataWr(busDataWr),
    .busWrEn(busWrEn), .cpuRdy(cpuRdy), .dmaActive(dmaActive),
    .dmaDone(dmaDone)
  );

  always #5 clk = ~clk;

  logic [7:0] ram [0:2047];

  function automatic logic [7:0] src(input logic [15:0] a);
    if (a < 16'h2000) return ram[a[10:0]];
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  assign busDataRd = src(busAddr);

  int tests = 0;
  int fails = 0;
  int nwrites = 0;
  int done_n = 0;
  int unsigned ecnt;

  logic [15:0] aq[$];
  logic [7:0]  dq[$];
  bit          weq[$];
  bit          pq[$];
  bit          hq[$];

  always @(posedge clk or posedge reset)
    if (reset) ecnt <= 0;
    else ecnt <= ecnt + 1;

  always @(negedge clk) begin
    if (!reset && dmaActive) begin
      aq.push_back(busAddr);
      dq.push_back(busDataWr);
      weq.push_back(busWrEn);
      pq.push_back(ecnt[0]);
      hq.push_back(busAddr == cpuAddr);
      if (busWrEn && busAddr == 16'h2004) nwrites++;
    end
    if (!reset && dmaDone) done_n++;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] rnd_addr();
    return 16'($urandom) | 16'h8000;
  endfunction

  task automatic xfer(input logic [7:0] pg, input bit par,
                      input bit chain, input int inj);
    int d0, n, hc, br, bw, hb;
    bit ok, g, injd;
    aq.delete(); dq.delete(); weq.delete(); pq.delete(); hq.delete();
    nwrites = 0;
    d0 = done_n;
    if (chain) chk("chain_done_high", 32'(dmaDone), 1);
    else while (ecnt[0] != par) tick();
    g = ecnt[0];
    cpuAddr = 16'h4014; cpuDataWr = pg; cpuWrEn = 1'b1;
    tick();
    cpuWrEn = 1'b0; cpuAddr = rnd_addr();
    chk("halt_rdy_act", {30'd0, cpuRdy, dmaActive}, 32'b01);
    ok = 0; injd = 0;
    for (int c = 0; c < 700 && !ok; c++) begin
      if (inj >= 0 && !injd && nwrites >= inj) begin
        cpuAddr = 16'h4014; cpuDataWr = 8'h07; cpuWrEn = 1'b1; injd = 1;
      end else begin
        cpuAddr = rnd_addr(); cpuDataWr = 8'($urandom);
        cpuWrEn = 1'($urandom);
      end
      tick();
      ok = dmaDone;
    end
    cpuWrEn = 1'b0;
    chk("done_seen", 32'(ok), 1);
    @(negedge clk); #1;
    chk("idle_rdy_act", {30'd0, cpuRdy, dmaActive}, 32'b10);
    chk("done_pulses", 32'(done_n - d0), 1);
    n = aq.size();
    chk("own_cycles", 32'(n), g ? 513 : 514);
    hc = (n >= 512) ? n - 512 : 0;
    hb = 0;
    for (int i = 0; i < hc; i++) if (weq[i] || !hq[i]) hb++;
    chk("halt_bus", 32'(hb), 0);
    br = 0; bw = 0;
    for (int i = 0; i < 256; i++) begin
      int r;
      r = hc + 2 * i;
      if (r + 1 >= n) begin
        br++; bw++;
      end else begin
        if (aq[r] !== {pg, 8'(i)} || weq[r]) br++;
        if (aq[r+1] !== 16'h2004 || !weq[r+1] ||
            dq[r+1] !== src({pg, 8'(i)})) bw++;
      end
    end
    chk("bad_reads", 32'(br), 0);
    chk("bad_writes", 32'(bw), 0);
    chk("oam_writes", 32'(nwrites), 256);
    if (hc < n) chk("first_read_parity", 32'(pq[hc]), 1);
    else chk("first_read_parity", 32'(n), 32'(hc + 1));
  endtask

  initial begin
    bit ok;
    reset = 1'b1; cpuAddr = 16'h0; cpuDataWr = 8'h0; cpuWrEn = 1'b0;
    for (int i = 0; i < 2048; i++) ram[i] = 8'($urandom);
    for (int i = 0; i < 256; i++) ram[11'h200 + 11'(i)] = 8'(i);
    #12;
    chk("rst_outputs", {29'd0, cpuRdy, dmaActive, dmaDone}, 32'b100);
    @(negedge clk); reset = 1'b0;
    tick();

    for (int k = 0; k < 6; k++) begin
      logic [15:0] a;
      logic [7:0]  d;
      logic        w;
      a = (k == 0) ? 16'h0300 : (k == 1) ? 16'h4000 : rnd_addr();
      d = 8'($urandom); w = (k < 2) ? 1'b1 : 1'($urandom);
      cpuAddr = a; cpuDataWr = d; cpuWrEn = w;
      #1;
      chk("pass_bus", {7'd0, busAddr, busDataWr, busWrEn}, {7'd0, a, d, w});
      tick();
      chk("pass_rdy_act", {30'd0, cpuRdy, dmaActive}, 32'b10);
    end
    cpuWrEn = 1'b0;

    xfer(8'h02, 1'b1, 1'b0, -1);
    xfer(8'h02, 1'b0, 1'b0, -1);
    xfer(8'h02, 1'($urandom), 1'b0, 100);
    xfer(8'($urandom_range(0, 7)), 1'($urandom), 1'b0, -1);
    xfer(8'($urandom_range(8'h20, 8'hFF)), 1'b0, 1'b1, -1);

    for (int i = 0; i < 2048; i++) ram[i] = 8'($urandom);
    aq.delete(); dq.delete(); weq.delete(); pq.delete(); hq.delete();
    nwrites = 0; done_n = 0;
    tick();
    cpuAddr = 16'h4014; cpuDataWr = 8'h03; cpuWrEn = 1'b1;
    tick();
    cpuWrEn = 1'b0; cpuAddr = rnd_addr();
    ok = 0;
    for (int c = 0; c < 200 && !ok; c++) begin
      tick();
      ok = (nwrites >= 40);
    end
    chk("reach_40_writes", 32'(nwrites), 40);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_ctl", {29'd0, cpuRdy, dmaActive, dmaDone}, 32'b100);
    chk("rst_mid_bus", 32'(busAddr), 32'(cpuAddr));
    repeat (3) tick();
    reset = 1'b0;
    repeat (20) tick();
    chk("rst_no_more_writes", 32'(nwrites), 40);
    chk("rst_no_done", 32'(done_n), 0);
    xfer(8'h05, 1'($urandom), 1'b0, -1);
    xfer(8'h01, 1'b0, 1'b1, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/oam_dma.md
Name: oam_dma

Overview:
- Sprite OAM DMA engine, placed directly downstream of the cpu bus outputs and upstream of the shared memory bus (RAM and memory select).
- Passes cpu bus traffic through when idle.
- A cpu write to $4014 triggers the engine: it halts the cpu and copies the 256-byte page $XX00-$XXFF to the PPU OAM data port ($2004) as 256 read/write pairs.
- Runs on cpuClk and owns the bus for 513 or 514 cycles per transfer.

Parameters:
- DMA_REG_ADDR, 16'h4014, cpu write address that triggers DMA
- OAM_DATA_ADDR, 16'h2004, destination address for every DMA write
- PAGE_LEN, 256, bytes per transfer (fixed; the index is 8 bits)

Ports:
- cpuClk  in  1  cpu clock; the only clock
- reset  in  1  asynchronous, active-high reset
- cpuAddr  in  16  cpu bus address
- cpuDataWr  in  8  cpu write data
- cpuWrEn  in  1  cpu write strobe
- busDataRd  in  8  read data returned from the memory bus
- busAddr  out  16  address driven to the memory bus
- busDataWr  out  8  write data driven to the memory bus
- busWrEn  out  1  write strobe driven to the memory bus
- cpuRdy  out  1  high = cpu may advance; low = cpu halted
- dmaActive  out  1  high while DMA owns the bus
- dmaDone  out  1  one-cycle pulse after the final OAM write

Behaviour:
- Interface: one clock (cpuClk); reset is asynchronous and active-high.
- Reset values:
  - state=IDLE, page=0, idx=0, latch=0, getCycle=0
  - cpuRdy=1, dmaActive=0, dmaDone=0
  - bus outputs in passthrough
- getCycle: a 1-bit register that toggles every cpuClk edge. It is the cycle parity used for alignment.
- Passthrough: in IDLE, busAddr/busDataWr/busWrEn are combinationally equal to cpuAddr/cpuDataWr/cpuWrEn.
- States: IDLE, HALT, ALIGN, READ, WRITE.
- IDLE:
  - If cpuWrEn=1 and cpuAddr==DMA_REG_ADDR, latch page<=cpuDataWr, set idx<=0, and go to HALT.
  - The trigger write itself passes through to the bus unchanged.
- HALT:
  - cpuRdy=0, dmaActive=1.
  - Bus outputs: addr=cpuAddr, wrEn=0.
  - Next state is READ if getCycle==0 in this cycle, else ALIGN.
- ALIGN:
  - Same outputs as HALT.
  - Next state is READ.
- READ:
  - busAddr={page,idx}, busWrEn=0.
  - At the cycle end, latch<=busDataRd (read data is valid in the same cycle).
  - Next state is WRITE.
- WRITE:
  - busAddr=OAM_DATA_ADDR, busDataWr=latch, busWrEn=1.
  - If idx==8'hFF: go to IDLE and assert dmaDone for exactly the first IDLE cycle.
  - Otherwise: idx<=idx+1 and go to READ.
- cpuRdy=0 and dmaActive=1 in every state except IDLE. cpuRdy returns to 1 in the first IDLE cycle.
- Latency: the trigger edge moves to HALT. The bus is owned for 1 HALT + 0/1 ALIGN + 512 READ/WRITE cycles, i.e. 513 cycles (no ALIGN) or 514 cycles (with ALIGN).
- The first READ always occurs in a cycle with getCycle==1.
- idx is 8-bit. The increment from 8'hFF never happens, because the exit is taken instead. The source address never leaves page XX.
- Page $00-$07 sources come from RAM through memory select, with normal mirroring. The engine does not special-case any page.
- While active, cpu writes to DMA_REG_ADDR are ignored: no retrigger and no page change. cpu bus inputs are ignored except in HALT/ALIGN, where cpuAddr is passed through.
- Simultaneous events: a trigger in the same cycle dmaDone is high is accepted, because dmaDone is asserted in IDLE.
- Reset mid-transfer: return to IDLE immediately (asynchronous). cpuRdy=1, dmaDone is not pulsed, and no further OAM write occurs.

Decomposition:
- nes_pkg (shared) holds:
  - typedef enum logic [2:0] dma_state_t {IDLE, HALT, ALIGN, READ, WRITE}
  - localparams ADDR_OAMDMA=16'h4014 and ADDR_OAMDATA=16'h2004, also used by memory_select and the future PPU register block
- No sub-module. The state register, index counter, parity bit and output mux stay in oam_dma. The expected size is about 150-200 lines.

Test Plan:
- Reset, then cpu writes cpuAddr=$0300 and cpuAddr=$4000 -> bus outputs mirror the cpu each cycle; cpuRdy=1 and dmaActive=0 throughout.
- Preload RAM $0200-$02FF with value=index; cpu writes $02 to $4014 with getCycle==1 at the trigger (getCycle==0 during HALT) -> 513 cycles with cpuRdy=0. Reads hit $0200..$02FF in order. The 256 writes go to $2004 with data $00..$FF. dmaDone pulses once, then cpuRdy=1.
- Same as above but with the trigger on the opposite parity -> an ALIGN cycle is inserted and cpuRdy is low for 514 cycles. The first READ has getCycle==1.
- Mid-transfer (after 100 writes), cpu asserts a write of $07 to $4014 -> ignored; the transfer completes from page $02 with an unchanged count.
- Assert reset after 40 OAM writes -> same-cycle return to passthrough: cpuRdy=1, dmaActive=0, no dmaDone, no further $2004 writes. A new trigger after reset starts cleanly from idx=0.
- Write $4014 in the cycle dmaDone is high -> a new transfer starts (HALT on the next cycle).
